// File: rtl/reg_file_sb.sv
// Register file with write-side load extension, optional same-cycle write bypass,
// and a pending-write scoreboard used by the control FSM for RAW hazard detection.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   Rs1,
  input  logic [AW-1:0]   Rs2,
  input  logic            use1,
  input  logic            use2,
  input  logic            we,
  input  logic [AW-1:0]   Rd,
  input  logic [XLEN-1:0] data_in,
  input  logic [2:0]      ext_mode,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            busy1,
  output logic            busy2,
  output logic            hazard,
  output logic [NREG-1:0] busy_vec
);

  typedef enum logic [2:0] {
    EXT_NONE = 3'b000,
    EXT_SB   = 3'b001,
    EXT_ZB   = 3'b010,
    EXT_SH   = 3'b011,
    EXT_ZH   = 3'b100
  } ext_e;

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic [XLEN-1:0] w_wval;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic            w_hit1;
  logic            w_hit2;

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wval = data_in;
    case (ext_mode)
      EXT_SB:  w_wval = {{(XLEN-8){data_in[7]}}, data_in[7:0]};
      EXT_ZB:  w_wval = {{(XLEN-8){1'b0}}, data_in[7:0]};
      EXT_SH:  w_wval = {{(XLEN-16){data_in[15]}}, data_in[15:0]};
      EXT_ZH:  w_wval = {{(XLEN-16){1'b0}}, data_in[15:0]};
      default: w_wval = data_in;
    endcase
  end

  // Set/clear decode; bit 0 is masked so x0 can never become busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid) w_set[issue_rd] = 1'b1;
    if (we)          w_clr[Rd]       = 1'b1;
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
  end

  // NOTE: the whole array is reset because every register must read 0 after
  // reset; this keeps the file in flops rather than an inferred RAM.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (we && (Rd != '0)) r_regs[Rd] <= w_wval;
      // A same-cycle issue wins over the write: the newer writer stays outstanding.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign w_hit1 = BYP && we && (Rd == Rs1);
  assign w_hit2 = BYP && we && (Rd == Rs2);

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (Rs1 != '0) read_data1 = w_hit1 ? w_wval : r_regs[Rs1];
    if (Rs2 != '0) read_data2 = w_hit2 ? w_wval : r_regs[Rs2];
  end

  assign busy1    = r_busy[Rs1] & ~w_hit1;
  assign busy2    = r_busy[Rs2] & ~w_hit2;
  assign hazard   = (use1 & busy1) | (use2 & busy2);
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one bypassing and one non-bypassing instance
// share the same stimulus and are compared against a behavioural model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, ird;
  logic        u1, u2, we, iv;
  logic [31:0] din;
  logic [2:0]  em;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n, bv_b, bv_n;
  logic        bsy1_b, bsy2_b, haz_b, bsy1_n, bsy2_n, haz_n;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .Rs1(rs1), .Rs2(rs2), .use1(u1), .use2(u2),
    .we(we), .Rd(rd), .data_in(din), .ext_mode(em),
    .issue_valid(iv), .issue_rd(ird),
    .read_data1(rd1_b), .read_data2(rd2_b), .busy1(bsy1_b), .busy2(bsy2_b),
    .hazard(haz_b), .busy_vec(bv_b)
  );

  reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .Rs1(rs1), .Rs2(rs2), .use1(u1), .use2(u2),
    .we(we), .Rd(rd), .data_in(din), .ext_mode(em),
    .issue_valid(iv), .issue_rd(ird),
    .read_data1(rd1_n), .read_data2(rd2_n), .busy1(bsy1_n), .busy2(bsy2_n),
    .hazard(haz_n), .busy_vec(bv_n)
  );

  typedef enum int {
    S_RD1B, S_RD2B, S_BSY1B, S_BSY2B, S_HAZB, S_BVB,
    S_RD1N, S_RD2N, S_BSY1N, S_BSY2N, S_HAZN, S_BVN
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_obs(input sel_e s);
    case (s)
      S_RD1B:  return rd1_b;
      S_RD2B:  return rd2_b;
      S_BSY1B: return {31'b0, bsy1_b};
      S_BSY2B: return {31'b0, bsy2_b};
      S_HAZB:  return {31'b0, haz_b};
      S_BVB:   return bv_b;
      S_RD1N:  return rd1_n;
      S_RD2N:  return rd2_n;
      S_BSY1N: return {31'b0, bsy1_n};
      S_BSY2N: return {31'b0, bsy2_n};
      S_HAZN:  return {31'b0, haz_n};
      default: return bv_n;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [2:0] m);
    case (m)
      3'd1:    return {{24{d[7]}}, d[7:0]};
      3'd2:    return {24'h0, d[7:0]};
      3'd3:    return {{16{d[15]}}, d[15:0]};
      3'd4:    return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] rs, input bit byp);
    if (rs == 5'd0) return 32'h0;
    if (byp && we && rd == rs) return m_ext(din, em);
    return m_regs[rs];
  endfunction

  function automatic logic m_bsy(input logic [4:0] rs, input bit byp);
    if (rs == 5'd0) return 1'b0;
    return m_busy[rs] && !(byp && we && rd == rs);
  endfunction

  task automatic exp_c(input string tag, input sel_e s, input logic [31:0] v);
    sb_q.push_back('{tag, s, v});
  endtask

  task automatic push_model();
    logic b1b, b2b, b1n, b2n;
    b1b = m_bsy(rs1, 1'b1); b2b = m_bsy(rs2, 1'b1);
    b1n = m_bsy(rs1, 1'b0); b2n = m_bsy(rs2, 1'b0);
    exp_c("rd1_b",  S_RD1B,  m_rd(rs1, 1'b1));
    exp_c("rd2_b",  S_RD2B,  m_rd(rs2, 1'b1));
    exp_c("busy1_b", S_BSY1B, {31'b0, b1b});
    exp_c("busy2_b", S_BSY2B, {31'b0, b2b});
    exp_c("hazard_b", S_HAZB, {31'b0, (u1 & b1b) | (u2 & b2b)});
    exp_c("bvec_b", S_BVB,   m_busy);
    exp_c("rd1_n",  S_RD1N,  m_rd(rs1, 1'b0));
    exp_c("rd2_n",  S_RD2N,  m_rd(rs2, 1'b0));
    exp_c("busy1_n", S_BSY1N, {31'b0, b1n});
    exp_c("busy2_n", S_BSY2N, {31'b0, b2n});
    exp_c("hazard_n", S_HAZN, {31'b0, (u1 & b1n) | (u2 & b2n)});
    exp_c("bvec_n", S_BVN,   m_busy);
  endtask

  task automatic model_edge();
    logic [31:0] wv;
    wv = m_ext(din, em);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_busy = 32'h0;
    end else begin
      if (we && rd != 5'd0) m_regs[rd] = wv;
      for (int r = 1; r < 32; r++) begin
        if (iv && ird == 5'(r))     m_busy[r] = 1'b1;
        else if (we && rd == 5'(r)) m_busy[r] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
    we = 1'b0; rd = 5'd0; din = 32'h0; em = 3'd0; iv = 1'b0; ird = 5'd0;
  endtask

  // Inputs are already driven by the caller; compare at negedge+1, then clock.
  task automatic step(input bit chk);
    sb_t e;
    @(negedge clk);
    if (chk) push_model();
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (chk) check(e.tag, get_obs(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
    model_edge();
  endtask

  logic [2:0]  ext_modes [5];
  logic [31:0] ext_exp   [5];

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;
    ext_modes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    ext_exp   = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0, 32'h000080F0};

    // Reset with a competing write, then a write to x0.
    idle(); rst = 1'b0; we = 1'b1; rd = 5'd5; din = 32'hDEADBEEF; step(1'b0);
    idle(); we = 1'b1; rd = 5'd0; din = 32'h1234; rs1 = 5'd5; rs2 = 5'd0;
    exp_c("rst_reg5", S_RD1N, 32'h0); exp_c("x0_byp", S_RD2B, 32'h0); step(1'b1);
    idle(); rs1 = 5'd0; rs2 = 5'd5;
    exp_c("x0_after", S_RD1N, 32'h0); exp_c("bvec_rst", S_BVB, 32'h0); step(1'b1);

    // Write-side extension of 0x000080F0 into x3.
    for (int i = 0; i < 5; i++) begin
      idle(); we = 1'b1; rd = 5'd3; din = 32'h000080F0; em = ext_modes[i]; rs1 = 5'd3;
      exp_c("ext_byp", S_RD1B, ext_exp[i]);
      if (i > 0) exp_c("ext_prev", S_RD1N, ext_exp[i-1]);
      step(1'b1);
    end
    idle(); rs1 = 5'd3; exp_c("ext_last", S_RD1N, ext_exp[4]); step(1'b1);

    // Bypass versus stored read.
    idle(); rs1 = 5'd7; rs2 = 5'd7; we = 1'b1; rd = 5'd7; din = 32'hA5A5A5A5;
    exp_c("byp_p1", S_RD1B, 32'hA5A5A5A5); exp_c("byp_p2", S_RD2B, 32'hA5A5A5A5);
    exp_c("nobyp_old1", S_RD1N, 32'h0);    exp_c("nobyp_old2", S_RD2N, 32'h0);
    step(1'b1);
    idle(); rs1 = 5'd7; rs2 = 5'd7;
    exp_c("nobyp_new1", S_RD1N, 32'hA5A5A5A5); exp_c("nobyp_new2", S_RD2N, 32'hA5A5A5A5);
    step(1'b1);

    // Scoreboard set, hazard, clear.
    idle(); iv = 1'b1; ird = 5'd9; step(1'b1);
    idle(); rs1 = 5'd9; u1 = 1'b1;
    exp_c("busy9", S_BSY1B, 32'h1); exp_c("haz9_b", S_HAZB, 32'h1); exp_c("haz9_n", S_HAZN, 32'h1);
    step(1'b1);
    idle(); rs1 = 5'd9; u1 = 1'b1; we = 1'b1; rd = 5'd9; din = 32'h99;
    exp_c("haz_mask_b", S_HAZB, 32'h0); exp_c("haz_keep_n", S_HAZN, 32'h1);
    step(1'b1);
    idle(); exp_c("bvec9_clr", S_BVB, 32'h0); step(1'b1);

    // Simultaneous set and clear on x4.
    idle(); iv = 1'b1; ird = 5'd4; step(1'b1);
    idle(); iv = 1'b1; ird = 5'd4; we = 1'b1; rd = 5'd4; din = 32'h44; step(1'b1);
    idle(); rs1 = 5'd4;
    exp_c("setclr_data", S_RD1N, 32'h44); exp_c("setclr_busy", S_BVB, 32'h10);
    step(1'b1);

    // Reset in the middle of outstanding writes.
    idle(); we = 1'b1; rd = 5'd2; din = 32'h55; iv = 1'b1; ird = 5'd6; step(1'b1);
    idle(); iv = 1'b1; ird = 5'd2; step(1'b1);
    idle(); rs1 = 5'd2;
    exp_c("pre_rst_bvec", S_BVB, 32'h54); exp_c("pre_rst_reg2", S_RD1N, 32'h55);
    step(1'b1);
    idle(); rst = 1'b0; iv = 1'b1; ird = 5'd8; rs1 = 5'd2; step(1'b1);
    idle(); rs1 = 5'd2;
    exp_c("mid_rst_bvec", S_BVB, 32'h0); exp_c("mid_rst_reg2", S_RD1N, 32'h0);
    step(1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      idle();
      rst = ($urandom_range(0, 24) != 0);
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      u1 = 1'($urandom_range(0, 1));  u2 = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));  rd = 5'($urandom_range(0, 31));
      din = $urandom();               em = 3'($urandom_range(0, 7));
      iv = 1'($urandom_range(0, 1));  ird = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rs1 = rd;
      if ($urandom_range(0, 3) == 0) rs2 = ird;
      step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the single- and multi-cycle RISC-V cores: XLEN-bit registers, NREG entries, two combinational read ports, and one write port with write-side load extension. It adds same-cycle write-to-read bypass and a per-register scoreboard of pending writes, so the multi-cycle control FSM can detect RAW hazards. It sits between decode (Rs1/Rs2/Rd, issue) and writeback (we, data_in, ext_mode).

## Interface
- XLEN, 32: register width in bits. Must be ≥16.
- NREG, 32: number of registers. Must be a power of two, ≥2.
- AW, $clog2(NREG): register address width. Derived; do not override.
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports; 0 = reads return the stored value.

- clk  in  1  clock; everything updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- Rs1  in  AW  read address, port 1.
- Rs2  in  AW  read address, port 2.
- use1, use2  in  1  decode actually consumes Rs1 / Rs2 this cycle; used only for hazard.
- we  in  1  write enable.
- Rd  in  AW  write address.
- data_in  in  XLEN  raw writeback data.
- ext_mode  in  3  write extension mode:
  - 000: none
  - 001: sign-extend byte
  - 010: zero-extend byte
  - 011: sign-extend half
  - 100: zero-extend half
  - 101–111: treated as none
- issue_valid  in  1  an instruction that will write issue_rd has issued.
- issue_rd  in  AW  destination of the issued instruction.
- read_data1, read_data2  out  XLEN  read data.
- busy1, busy2  out  1  Rs1 / Rs2 has a pending write.
- hazard  out  1  (use1 & busy1) | (use2 & busy2).
- busy_vec  out  NREG  scoreboard state, for debug and verification.

## Operation
- Write value wval is data_in after ext_mode:
  - byte modes use data_in[7:0]; half modes use data_in[15:0];
  - sign modes replicate bit 7 / bit 15 up to XLEN-1; zero modes fill with 0.
- Register 0 is hardwired to 0. Writes to 0 are discarded, busy_vec[0] is always 0, and issue_rd==0 sets nothing.
- Write: on a clock edge with rst=1, we=1 and Rd≠0, regs[Rd] ← wval.
- Read port k (Rsk):
  - If BYPASS=1 and we=1 and Rd==Rsk and Rsk≠0: read_datak = wval.
  - Otherwise: read_datak = regs[Rsk].
  - Both ports may address the same register, and both see the bypass.
- Scoreboard, per register r≠0, next state of busy_vec[r]:
  - set if issue_valid & issue_rd==r;
  - else clear if we & Rd==r;
  - else hold.
  - Simultaneous set and clear of the same r: set wins (the newer writer is outstanding).
  - Setting an already-busy register: it stays busy (single bit, no counting).
  - A write to a non-busy register is legal; it writes the data and busy stays 0.
- busyk:
  - BYPASS=1: busy_vec[Rsk] & ~(we & Rd==Rsk).
  - BYPASS=0: busy_vec[Rsk].
  - Rsk==0 gives busyk=0.
- hazard is purely combinational from busy1/busy2/use1/use2.

## Timing
- Reset (rst=0 at a rising edge): all regs ← 0 and busy_vec ← 0.
  - Reset has priority over a write or issue in the same cycle.
  - After reset, read_data1/2=0, busy1/2=0, hazard=0.
  - While rst=0 the outputs still follow the combinational rules; the state clears at the edge.
- Read latency 0 (combinational from Rs, regs, and the bypass inputs).
- Write latency 1 edge. With BYPASS=0, a value becomes readable the cycle after the edge.
- Scoreboard latency 1 edge:
  - issue in cycle N → busy visible in cycle N+1;
  - write in cycle N → busy clear in N+1, or already masked in N when BYPASS=1.
- The only combinational paths are Rs/Rd/we/data_in/ext_mode/use → outputs. Nothing combinational crosses the registers.

## Test plan
- Reset and x0:
  - Stimulus: rst=0 for one edge with we=1, Rd=5, data_in=0xDEADBEEF; then we=1, Rd=0, data_in=0x1234.
  - Required: all reads 0; regs[5]=0; x0 reads 0; busy_vec=0.
- Extension:
  - Stimulus: write Rd=3 with data_in=0x000080F0 using ext_mode 001, 010, 011, 100, 000 in turn.
  - Required: reg3 reads 0xFFFFFFF0, 0x000000F0, 0xFFFF80F0, 0x000080F0, 0x000080F0.
- Bypass:
  - Stimulus: BYPASS=1, Rs1=Rs2=7, we=1, Rd=7, data_in=0xA5A5A5A5, ext_mode=000.
  - Required: both ports read 0xA5A5A5A5 in the same cycle.
  - Stimulus: repeat with BYPASS=0.
  - Required: old value in the same cycle, 0xA5A5A5A5 in the next cycle.
- Scoreboard and hazard:
  - Stimulus: issue_rd=9; next cycle Rs1=9, use1=1.
  - Required: busy1=1, hazard=1.
  - Stimulus: then we=1, Rd=9.
  - Required: hazard=0 in the same cycle (BYPASS=1); busy_vec[9]=0 in the next cycle.
- Simultaneous set and clear:
  - Stimulus: busy_vec[4]=1; in one cycle issue_valid=1, issue_rd=4 and we=1, Rd=4.
  - Required: reg4 is written and busy_vec[4]=1 afterwards.
- Reset mid-operation:
  - Stimulus: busy_vec[2]=1 and busy_vec[6]=1 with reg2=0x55; assert rst=0 for one edge together with an issue to register 8.
  - Required: busy_vec=0, reg2=0, busy_vec[8]=0.
